// File: rtl/timer_pkg.sv
// Shared constants and helpers for the BCD countdown timer.
// State encoding is fixed because it is exported on the state port.
package timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  // Out-of-range BCD codes (A..F) load as 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a down-counter: clamped load, decrement on borrow_i,
// and a borrow_o to the next more-significant digit when wrapping 0 -> 9.
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [BCD_W-1:0] preset_i,
  input  logic             en_i,
  input  logic             borrow_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             borrow_o
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;
  logic             dec;

  assign dec = en_i & borrow_i;

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = bcd_clamp(preset_i);
    end else if (dec) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o  = digit_q;
  assign borrow_o = dec & (digit_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// BCD countdown timer driven by an upstream prescaler tick; on expiry it
// pulses done and holds alarm for ALARM_TICKS ticks before returning to IDLE.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int ALARM_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   value,
  output logic [1:0]            state,
  output logic                  done,
  output logic                  alarm
);

  localparam int VW = BCD_W * DIGITS;
  localparam logic [VW-1:0] VAL_ONE    = VW'(1);
  localparam logic [3:0]    ALARM_INIT = 4'(ALARM_TICKS);

  state_e        state_q;
  logic          done_q;
  logic          alarm_q;
  logic [3:0]    alarm_cnt_q;

  logic          in_run;
  logic          load_acc;
  logic          value_nz;
  logic          expire;
  logic [DIGITS:0] borrow;

  assign in_run   = (state_q == ST_RUN);
  assign load_acc = load & ~in_run;
  assign value_nz = (value != '0);
  // Expiry is the RUN tick that moves the count from 1 to 0.
  assign expire   = in_run & tick & (value == VAL_ONE);

  assign borrow[0] = tick & in_run;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_down u_digit (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load_acc),
      .preset_i (preset[i*BCD_W +: BCD_W]),
      .en_i     (in_run),
      .borrow_i (borrow[i]),
      .digit_o  (value[i*BCD_W +: BCD_W]),
      .borrow_o (borrow[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (load) begin
            state_q <= ST_IDLE;
            alarm_q <= 1'b0;
          end else if (start && value_nz) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (expire) begin
            state_q     <= ST_ALARM;
            done_q      <= 1'b1;
            alarm_q     <= 1'b1;
            alarm_cnt_q <= ALARM_INIT;
          end else if (pause) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_ALARM: begin
          if (load) begin
            state_q     <= ST_IDLE;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
          end else if (tick) begin
            if (alarm_cnt_q <= 4'd1) begin
              state_q     <= ST_IDLE;
              alarm_q     <= 1'b0;
              alarm_cnt_q <= '0;
            end else begin
              alarm_cnt_q <= alarm_cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A borrow out of the top digit would mean the count underflowed.
  assert property (@(posedge clk) disable iff (rst) !borrow[DIGITS]);

  assign state = state_q;
  assign done  = done_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with DIGITS=2, ALARM_TICKS=4.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic [7:0] preset = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] value;
  logic [1:0] state;
  logic       done;
  logic       alarm;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  countdown_timer #(.DIGITS(2), .ALARM_TICKS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .load   (load),
    .preset (preset),
    .start  (start),
    .pause  (pause),
    .value  (value),
    .state  (state),
    .done   (done),
    .alarm  (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic t, input logic l, input logic [7:0] p,
                     input logic s, input logic pa);
    tick = t; load = l; preset = p; start = s; pause = pa;
    @(posedge clk);
    #1;
    tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] v, input logic [1:0] st,
                         input logic d, input logic a);
    chk({tag, ".value"}, 32'(value), 32'(v));
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".alarm"}, 32'(alarm), 32'(a));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst", 8'h00, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_all("idle_tick", 8'h00, 2'd0, 1'b0, 1'b0);

    // Count 03 -> 00 and expire
    cyc(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    chk_all("load03", 8'h03, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("start03", 8'h03, 2'd1, 1'b0, 1'b0);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_all("cnt", exp_q.pop_front(), 2'd1, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_all("expire", 8'h00, 2'd3, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_all("alarm_hold", 8'h00, 2'd3, 1'b0, 1'b1);

    // Alarm lasts 4 ticks, back-to-back
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      chk_all("alarm_tick", 8'h00, 2'd3, 1'b0, 1'b1);
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_all("alarm_end", 8'h00, 2'd0, 1'b0, 1'b0);

    // Borrow across digits, then clamp on load from PAUSE
    cyc(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_all("borrow", 8'h09, 2'd1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_all("pause09", 8'h09, 2'd2, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    chk_all("clamp", 8'h95, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hFC, 1'b1, 1'b0);
    chk_all("clamp_lo", 8'h99, 2'd0, 1'b0, 1'b0);

    // Pause with tick, frozen in PAUSE, resume, load ignored in RUN
    cyc(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_all("pause_tick", 8'h04, 2'd2, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_all("frozen", 8'h04, 2'd2, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("resume", 8'h04, 2'd1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    chk_all("load_in_run", 8'h04, 2'd1, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN, checked before any clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 8'h00, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Start with zero value stays IDLE
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("start_zero", 8'h00, 2'd0, 1'b0, 1'b0);

    // Expire with pause on the same tick, then load during ALARM
    cyc(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk_all("expire_pause", 8'h00, 2'd3, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_all("alarm1", 8'h00, 2'd3, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
    chk_all("load_alarm", 8'h42, 2'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Downstream consumer of the mod-11 down-counter prescale stage.
- Takes that stage's one-cycle terminal-count pulse as `tick` and runs a DIGITS-wide BCD countdown timer with load/start/pause control.
- On reaching zero, emits a done pulse and then holds an alarm for ALARM_TICKS ticks.
- Sits between the tick prescaler and the display/alarm logic.

Parameters:
- DIGITS, 2, number of BCD digits in the count value (1..4).
- ALARM_TICKS, 4, number of ticks the alarm output is held after expiry (1..15).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- tick  input  1  one-cycle count-enable pulse from the upstream prescale stage
- load  input  1  load `preset` into the count value
- preset  input  4*DIGITS  BCD preset, digit 0 in [3:0]
- start  input  1  start/resume request, level sampled per cycle
- pause  input  1  pause request, level sampled per cycle
- value  output  4*DIGITS  current BCD count, registered
- state  output  2  current FSM state: IDLE=0, RUN=1, PAUSE=2, ALARM=3
- done  output  1  one-cycle pulse on expiry
- alarm  output  1  high while in ALARM

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (`clk`, `rst`).
- Reset values: state=IDLE, value=0, done=0, alarm=0, alarm counter=0. Reset mid-RUN or mid-ALARM aborts immediately, no done pulse.
- All outputs are registered. Every effect appears on the clk edge that samples the request/tick (1-cycle latency).
- Request priority when several are asserted: load > start > pause.
- load:
  - Accepted in IDLE, PAUSE and ALARM; ignored in RUN.
  - Next state is IDLE, value=preset, alarm=0.
  - Any preset digit >9 is clamped to 9.
- start:
  - In IDLE or PAUSE with value≠0 → RUN.
  - With value=0 → no state change, no done.
  - Ignored in RUN and ALARM.
- pause: in RUN → PAUSE, value frozen. Ignored elsewhere.
- tick in RUN:
  - value decrements by 1 in BCD. A digit at 0 becomes 9 and borrows from the next digit.
  - A tick on the same cycle as pause is still applied.
- Expiry, when a RUN tick takes value from 1 to 0:
  - On that edge: value=0, state=ALARM, done=1 for exactly one cycle, alarm=1, alarm counter=ALARM_TICKS.
  - If pause coincides with the expiring tick, expiry wins: ALARM, not PAUSE.
- ALARM:
  - Each tick decrements the alarm counter.
  - On the tick that takes it to 0: alarm=0, state=IDLE on that edge.
  - Alarm is therefore high for exactly ALARM_TICKS ticks.
  - Non-tick cycles hold the alarm counter.
- tick in IDLE or PAUSE: no effect.
- Wrap-around: value never underflows, because 0 in RUN is unreachable (expiry exits RUN).
- Max value is all nines.
- Ticks arrive at most once per cycle; back-to-back ticks (every cycle) must be handled.
- done is 0 in every cycle other than the expiry edge.

Decomposition:
- Shared package `timer_pkg`:
  - State encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM (2-bit).
  - BCD_W=4.
  - BCD_MAX=4'd9.
- Sub-module `bcd_digit_down`:
  - One digit with load, clamp, enable, borrow_in, borrow_out.
  - It is instantiated DIGITS times in a generate chain. Digit 0's borrow_in is `tick` qualified by RUN.
- FSM and alarm counter live in the top.

Test Plan:
- rst=1 mid-operation → value=00, state=0, done=0, alarm=0 immediately, without waiting for a clock edge.
- preset=8'h03, load, start, then 3 ticks → value 03→02→01→00. done high exactly one cycle on the third tick edge. state=3, alarm=1.
- After expiry with ALARM_TICKS=4 → alarm stays high through 3 ticks and drops on the 4th tick edge. state=0.
- preset=8'h10, run, 1 tick → value=8'h09 (borrow). preset=8'hA5 load → value=8'h95 (clamp).
- preset=8'h05 running:
  - pause together with a tick → value=04, state=2.
  - Further ticks → value holds 04.
  - start → state=1.
  - load during RUN → ignored.
- value=00 in IDLE, start → stays IDLE, no done. load asserted during ALARM → IDLE, alarm=0, value=preset.
